// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a small in-order queue toward decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  if ((QDEPTH != 2) && (QDEPTH != 4) && (QDEPTH != 8)) begin : g_bad_qdepth
    $error("fetch_unit: QDEPTH must be 2, 4 or 8");
  end

  logic [31:0]      pc_q;
  logic [31:0]      req_pc_q;
  logic             out_q;
  logic             discard_q;
  entry_t           q_mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             not_empty;
  logic             resp;
  logic             push;
  logic             pop;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // A slot freed by this cycle's pop may be claimed by this cycle's request,
  // which is what lets a 1-cycle memory sustain one instruction per cycle.
  always_comb begin
    not_empty = (count_q != '0);
    resp      = out_q & imem_rvalid_i;
    push      = resp & ~discard_q & ~redirect_i & ~rst_i;
    pop       = not_empty & id_ready_i & ~redirect_i & ~rst_i;
    occ       = OCC_W'(count_q) + OCC_W'(out_q) - OCC_W'(pop);
    issue     = ~rst_i & ~redirect_i & (~out_q | imem_rvalid_i) & (occ < OCC_W'(QDEPTH));
  end

  assign imem_req_o   = issue;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = not_empty & ~rst_i;
  assign inst_o       = inst_valid_o ? q_mem[rd_ptr_q].inst : NOP_INST;
  assign pc_o         = inst_valid_o ? q_mem[rd_ptr_q].pc : 32'h0000_0000;

  // Fetch PC, outstanding-request tracking and stale-response discard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_ADDR;
      req_pc_q  <= 32'h0000_0000;
      out_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      if (redirect_i) begin
        pc_q <= {redirect_pc_i[31:2], 2'b00};
      end else if (issue) begin
        pc_q <= pc_q + 32'd4;
      end

      if (issue) begin
        req_pc_q <= pc_q;
        out_q    <= 1'b1;
      end else if (resp) begin
        out_q <= 1'b0;
      end

      // A response coinciding with the redirect is dropped directly, so only
      // a still-pending request needs the discard marker.
      if (redirect_i && out_q && !imem_rvalid_i) begin
        discard_q <= 1'b1;
      end else if (resp) begin
        discard_q <= 1'b0;
      end
    end
  end

  // Queue storage carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_mem[wr_ptr_q] <= '{pc: req_pc_q, inst: imem_rdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (redirect_i) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign fetch_cnt_o = 32'h0000_0000;
  assign flush_cnt_o = 32'h0000_0000;
`endif

  // Target low bits are forced to word alignment and never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: latency-programmable imem model, pop scoreboard,
// and a second instance with a wrapping RESET_PC.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_rvalid, redirect, inst_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, pc, fetch_cnt, flush_cnt;

  logic        req_w, rvalid_w, valid_w;
  logic [31:0] addr_w, rdata_w, inst_w, pc_w, fcnt_w, flcnt_w;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int unsigned req_cyc[$];
  logic [31:0] req_log_w[$];
  logic [63:0] act_q[$];
  logic [63:0] exp_q[$];

  int unsigned mcyc;
  int unsigned mem_lat;
  int          hit;
  logic        w_pend;
  logic [31:0] w_addr;
  int          n_vec;
  int          n_err;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .inst_valid_o(inst_valid), .inst_o(inst), .pc_o(pc),
    .id_ready_i(id_ready),
    .fetch_cnt_o(fetch_cnt), .flush_cnt_o(flush_cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_w (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req_w), .imem_addr_o(addr_w),
    .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
    .redirect_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .inst_valid_o(valid_w), .inst_o(inst_w), .pc_o(pc_w),
    .id_ready_i(1'b1),
    .fetch_cnt_o(fcnt_w), .flush_cnt_o(flcnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory responders drive on the falling edge; requests and pops are sampled just before the rising edge.
  always begin
    @(negedge clk);
    mcyc        = mcyc + 1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    hit         = -1;
    foreach (pend_q[i]) if (hit < 0 && pend_q[i].due == mcyc) hit = i;
    if (hit >= 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memfn(pend_q[hit].addr);
      pend_q.delete(hit);
    end
    rvalid_w = w_pend;
    rdata_w  = memfn(w_addr);
    #4;
    if (imem_req) begin
      pend_q.push_back('{due: mcyc + mem_lat, addr: imem_addr});
      req_log.push_back(imem_addr);
      req_cyc.push_back(mcyc);
    end
    w_pend = req_w;
    w_addr = addr_w;
    if (req_w) req_log_w.push_back(addr_w);
    if (inst_valid && id_ready && !redirect) act_q.push_back({pc, inst});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_pop(input logic [31:0] p);
    exp_q.push_back({p, memfn(p)});
  endtask

  task automatic check_pops(input string tag);
    logic [63:0] a;
    logic [63:0] e;
    for (int i = 0; i < 64 && act_q.size() > 0; i++) begin
      a = act_q.pop_front();
      e = 64'hDEAD_BEEF_DEAD_BEEF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_pop"}, a, e);
    end
    chk({tag, "_missing_pops"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic clear_logs();
    req_log.delete();
    req_cyc.delete();
    req_log_w.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; mcyc = 0; mem_lat = 1;
    w_pend = 1'b0; w_addr = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; rvalid_w = 1'b0; rdata_w = 32'h0;
    rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();

    // Reset state
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'(NOP_INST));
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    chk("rst_w_valid", 64'(valid_w), 64'd0);
    chk("rst_w_cnts", 64'({fcnt_w, flcnt_w}), 64'd0);

    // Phase A: free-running fetch out of reset, 1-cycle memory
    clear_logs();
    rst = 1'b0;
    step();
    chk("A_c1_valid", 64'(inst_valid), 64'd0);
    chk("A_c1_w_valid", 64'(valid_w), 64'd0);
    step();
    chk("A_c2_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h0});
    chk("A_c2_inst", 64'(inst), 64'(memfn(32'h0)));
    chk("A_c2_w_pc", 64'(pc_w), 64'(32'hFFFF_FFF8));
    chk("A_c2_w_inst", 64'(inst_w), 64'(memfn(32'hFFFF_FFF8)));
    step();
    chk("A_c3_pc", 64'(pc), 64'h4);
    chk("A_c3_w_pc", 64'(pc_w), 64'(32'hFFFF_FFFC));
    step();
    chk("A_c4_pc", 64'(pc), 64'h8);
    chk("A_c4_w_pc", 64'({valid_w, pc_w}), {31'd0, 1'b1, 32'h0});
    chk("A_req0", 64'(req_log[0]), 64'h0);
    chk("A_req1", 64'(req_log[1]), 64'h4);
    chk("A_req2", 64'(req_log[2]), 64'h8);
    chk("A_req_gap01", 64'(req_cyc[1] - req_cyc[0]), 64'd1);
    chk("A_req_gap12", 64'(req_cyc[2] - req_cyc[1]), 64'd1);
    chk("A_w_req0", 64'(req_log_w[0]), 64'(32'hFFFF_FFF8));
    chk("A_w_req1", 64'(req_log_w[1]), 64'(32'hFFFF_FFFC));
    chk("A_w_req2", 64'(req_log_w[2]), 64'h0);
    expect_pop(32'h0); expect_pop(32'h4);
    rst = 1'b1;
    step(); step();
    check_pops("A");

    // Phase B: decode stalled, queue fills and fetch stops
    id_ready = 1'b0;
    clear_logs();
    rst = 1'b0;
    step(); step(); step();
    chk("B_c3_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h0});
    step(); step(); step();
    chk("B_c6_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h0});
    chk("B_c6_inst", 64'(inst), 64'(memfn(32'h0)));
    chk("B_c6_req", 64'(imem_req), 64'd0);
    chk("B_req_count", 64'(req_log.size()), 64'd2);
    chk("B_req1", 64'(req_log[1]), 64'h4);
    id_ready = 1'b1;
    step();
    chk("B_c7_pc", 64'(pc), 64'h4);
    step();
    chk("B_c8_pc", 64'(pc), 64'h8);
    expect_pop(32'h0); expect_pop(32'h4);
    rst = 1'b1;
    step(); step();
    check_pops("B");

    // Phase C: redirect over a slow outstanding request, then over a live response
    clear_logs();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("C_c7_pc", 64'(pc), 64'd20);
    mem_lat = 3;
    step();
    chk("C_c8_pc", 64'(pc), 64'd24);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    mem_lat = 1;
    #1;
    chk("C_c9_valid", 64'(inst_valid), 64'd0);
    chk("C_c9_req", 64'(imem_req), 64'd0);
    step();
    chk("C_c10_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h100});
    step(); step();
    chk("C_c12_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h100});
    step();
    chk("C_c13_pc", 64'(pc), 64'h104);
    step();
    chk("C_c14_pc", 64'(pc), 64'h108);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    #1;
    chk("C_c15_valid", 64'(inst_valid), 64'd0);
    chk("C_c15_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h200});
    step(); step();
    chk("C_c17_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h200});
    step();
    chk("C_c18_pc", 64'(pc), 64'h204);
    mem_lat = 2;
    step();
`ifdef FETCH_PERF_CNT_EN
    chk("C_fetch_cnt", 64'(fetch_cnt), 64'd10);
    chk("C_flush_cnt", 64'(flush_cnt), 64'd2);
`else
    chk("C_fetch_cnt", 64'(fetch_cnt), 64'd0);
    chk("C_flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    for (int i = 0; i < 6; i++) expect_pop(32'(4 * i));
    expect_pop(32'h100); expect_pop(32'h104);
    expect_pop(32'h200); expect_pop(32'h204);
    rst = 1'b1;
    mem_lat = 1;

    // Phase E: a response to a pre-reset request lands in the first cycle out of reset
    step();
    rst = 1'b0;
    step();
    chk("E_c1_valid", 64'(inst_valid), 64'd0);
    step();
    chk("E_c2_head", {31'd0, inst_valid, pc}, {31'd0, 1'b1, 32'h0});
    chk("E_c2_inst", 64'(inst), 64'(memfn(32'h0)));
    rst = 1'b1;
    step(); step();
    check_pops("CE");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
